// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter from two byte requesters, with a tx_busy handshake timeout.
// Latency: grant to tx_valid is 1 cycle; backpressure: no grants while tx_busy is high or a byte is in flight.
module uart_tx_arb #(
  parameter int TMO_CYCLES = 16,
  parameter int CW         = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       tx_timeout,
  output logic       idle
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last;
  logic          win0, win1, do_grant, tmo_hit;

  // last=1 means requester 1 was served most recently, so requester 0 wins a tie
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (state == IDLE && !tx_busy) begin
      if (req0_valid && req1_valid) begin
        win0 = last;
        win1 = !last;
      end else begin
        win0 = req0_valid;
        win1 = req1_valid;
      end
    end
  end

  assign do_grant = win0 | win1;
  assign tmo_hit  = (state == WAIT_BUSY) && !tx_busy && (cnt == TMO_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (do_grant) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)      state_nxt = WAIT_DONE;
        else if (tmo_hit) state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = win0 && !reset;
    req1_ready = win1 && !reset;
    idle       = (state == IDLE);
    tx_timeout = tmo_hit;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      grant    <= 2'b00;
      cnt      <= '0;
      last     <= 1'b1;
    end else begin
      tx_valid <= do_grant;
      if (do_grant) begin
        tx_data <= win1 ? req1_data : req0_data;
        grant   <= {win1, win0};
        last    <= win1;
      end
      case (state)
        LAUNCH: cnt <= '0;
        WAIT_BUSY: begin
          if (tx_busy) begin
            cnt <= '0;
          end else if (tmo_hit) begin
            cnt   <= '0;
            grant <= 2'b00;
          end else if (cnt != TMO_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: if (!tx_busy) grant <= 2'b00;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: UART busy model plus a scoreboard of expected bytes popped on each tx_valid.
module tb_uart_tx_arb;
  localparam int TMO = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] req0_data, req1_data, tx_data;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic       tx_valid, tx_busy, tx_timeout, idle;
  logic [1:0] grant;
  logic       ext_busy, uart_en;
  logic [3:0] uart_cnt;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  uart_tx_arb #(.TMO_CYCLES(TMO), .CW(5)) dut (
    .clock(clock), .reset(reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .grant(grant), .tx_timeout(tx_timeout), .idle(idle)
  );

  always #5 clock = ~clock;

  // UART model: busy for 10 cycles after each strobe
  assign tx_busy = ext_busy | (uart_cnt != 4'd0);
  always @(posedge clock or posedge reset) begin
    if (reset)                  uart_cnt <= 4'd0;
    else if (uart_en && tx_valid) uart_cnt <= 4'd10;
    else if (uart_cnt != 4'd0)  uart_cnt <= uart_cnt - 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!idle && k < 60) begin
      tick();
      k++;
    end
    check(tag, 32'(idle), 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!(req0_ready || req1_ready) && k < 60) begin
      tick();
      k++;
    end
    check(tag, 32'(req0_ready | req1_ready), 32'd1);
  endtask

  // Scoreboard: each strobe must match the oldest expected byte
  always @(negedge clock) begin
    if (tx_valid) begin
      if (exp_q.size() == 0) begin
        check("strobe_without_expected_byte", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("tx_data_scoreboard", 32'(tx_data), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1;
    req0_data = 8'h00; req1_data = 8'h00;
    req0_valid = 1'b0; req1_valid = 1'b0;
    ext_busy = 1'b0; uart_en = 1'b1;

    // Reset state, with a requester already waiting
    req0_data = 8'h41; req0_valid = 1'b1;
    tick(); tick();
    check("rst_idle",       32'(idle),       32'd1);
    check("rst_grant",      32'(grant),      32'd0);
    check("rst_tx_data",    32'(tx_data),    32'd0);
    check("rst_tx_valid",   32'(tx_valid),   32'd0);
    check("rst_tx_timeout", 32'(tx_timeout), 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);

    // Single transfer from requester 0
    reset = 1'b0;
    exp_q.push_back(8'h41);
    #1;
    check("t1_req0_ready", 32'(req0_ready), 32'd1);
    check("t1_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    check("t1_tx_valid", 32'(tx_valid), 32'd1);
    check("t1_tx_data",  32'(tx_data),  32'h41);
    check("t1_grant",    32'(grant),    32'd1);
    check("t1_ready_drop", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    wait_idle("t1_idle");
    check("t1_grant_idle", 32'(grant), 32'd0);

    // Round robin from a fresh pointer: 55, AA, 55
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_data = 8'h55; req1_data = 8'hAA;
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp_q.push_back(8'h55); exp_q.push_back(8'hAA); exp_q.push_back(8'h55);
    #1;
    for (int k = 0; k < 3; k++) begin
      wait_ready($sformatf("rr_ready_%0d", k));
      check($sformatf("rr_r0_%0d", k), 32'(req0_ready), 32'(k != 1));
      check($sformatf("rr_r1_%0d", k), 32'(req1_ready), 32'(k == 1));
      tick();
      check($sformatf("rr_pulse_%0d", k), 32'(req0_ready | req1_ready), 32'd0);
      check($sformatf("rr_grant_%0d", k), 32'(grant), (k == 1) ? 32'd2 : 32'd1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("rr_idle");

    // Timeout: UART never reports busy
    uart_en = 1'b0;
    req1_data = 8'h3C; req1_valid = 1'b1;
    exp_q.push_back(8'h3C);
    #1;
    check("tmo_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    check("tmo_tx_valid", 32'(tx_valid), 32'd1);
    req1_valid = 1'b0;
    seen = 1'b0;
    for (int i = 1; i < TMO; i++) begin
      tick();
      if (tx_timeout) seen = 1'b1;
    end
    check("tmo_not_early", 32'(seen), 32'd0);
    tick();
    check("tmo_pulse", 32'(tx_timeout), 32'd1);
    check("tmo_grant_held", 32'(grant), 32'd2);
    tick();
    check("tmo_pulse_end", 32'(tx_timeout), 32'd0);
    check("tmo_idle",      32'(idle),       32'd1);
    check("tmo_grant_clr", 32'(grant),      32'd0);
    uart_en = 1'b1;

    // External busy in IDLE blocks the grant
    ext_busy = 1'b1;
    req1_data = 8'h99; req1_valid = 1'b1;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (req0_ready || req1_ready) seen = 1'b1;
      tick();
    end
    check("busy_no_ready", 32'(seen), 32'd0);
    ext_busy = 1'b0;
    exp_q.push_back(8'h99);
    #1;
    check("busy_ready_after", 32'(req1_ready), 32'd1);
    tick();
    check("busy_grant",    32'(grant),    32'd2);
    check("busy_tx_valid", 32'(tx_valid), 32'd1);
    req1_valid = 1'b0;
    wait_idle("busy_idle");

    // Reset during WAIT_DONE
    req0_data = 8'h77; req0_valid = 1'b1;
    exp_q.push_back(8'h77);
    #1;
    check("wd_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    check("wd_not_idle", 32'(idle), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_idle",       32'(idle),       32'd1);
    check("arst_grant",      32'(grant),      32'd0);
    check("arst_tx_data",    32'(tx_data),    32'd0);
    check("arst_tx_valid",   32'(tx_valid),   32'd0);
    check("arst_tx_timeout", 32'(tx_timeout), 32'd0);
    req0_data = 8'h11; req1_data = 8'h22;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("arst_readys", 32'({req1_ready, req0_ready}), 32'd0);
    tick(); tick();
    reset = 1'b0;
    exp_q.push_back(8'h11);
    #1;
    check("rel_tx_valid", 32'(tx_valid),   32'd0);
    check("rel_req0_win", 32'(req0_ready), 32'd1);
    check("rel_req1_wait", 32'(req1_ready), 32'd0);
    tick();
    check("rel_grant", 32'(grant), 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("rel_idle");
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
